// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 VGA timing constants and TinyVGA Pmod byte packing shared by the sync generator.
package vga_timing_pkg;

   localparam int unsigned H_DISPLAY = 640;
   localparam int unsigned H_FRONT   = 16;
   localparam int unsigned H_SYNC    = 96;
   localparam int unsigned H_BACK    = 48;
   localparam int unsigned V_DISPLAY = 480;
   localparam int unsigned V_FRONT   = 10;
   localparam int unsigned V_SYNC    = 2;
   localparam int unsigned V_BACK    = 33;

   localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam int unsigned CNT_W   = 10;
   localparam int unsigned FRAME_W = 8;
   localparam int unsigned PMOD_W  = 8;

   // TinyVGA Pmod pin order: {hsync, b0, g0, r0, vsync, b1, g1, r1}
   localparam int unsigned UO_HSYNC = 7;
   localparam int unsigned UO_B0    = 6;
   localparam int unsigned UO_G0    = 5;
   localparam int unsigned UO_R0    = 4;
   localparam int unsigned UO_VSYNC = 3;
   localparam int unsigned UO_B1    = 2;
   localparam int unsigned UO_G1    = 1;
   localparam int unsigned UO_R1    = 0;

   function automatic logic [PMOD_W-1:0] pmod_pack(input logic hs, input logic vs,
                                                   input logic [1:0] r, input logic [1:0] g,
                                                   input logic [1:0] b);
      logic [PMOD_W-1:0] p;
      p           = '0;
      p[UO_HSYNC] = hs;
      p[UO_B0]    = b[0];
      p[UO_G0]    = g[0];
      p[UO_R0]    = r[0];
      p[UO_VSYNC] = vs;
      p[UO_B1]    = b[1];
      p[UO_G1]    = g[1];
      p[UO_R1]    = r[1];
      return p;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrap counter with registered sync decode and next-state active/start decodes.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int unsigned TOTAL      = H_TOTAL,
   parameter int unsigned SYNC_START = H_DISPLAY + H_FRONT,
   parameter int unsigned SYNC_END   = H_DISPLAY + H_FRONT + H_SYNC - 1,
   parameter int unsigned ACTIVE     = H_DISPLAY
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             wrap_c_o,
   output logic             active_d_c_o,
   output logic             start_d_c_o,
   output logic             sync_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sync_q, sync_d;
   logic             wrap;

   // Next count plus decodes of that next value, so the parent can register strobes in step.
   always_comb begin
      wrap         = (cnt_q == CNT_W'(TOTAL - 1));
      cnt_d        = cnt_q;
      if (en_i) begin
         cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
      end
      sync_d       = (cnt_d >= CNT_W'(SYNC_START)) && (cnt_d <= CNT_W'(SYNC_END));
      active_d_c_o = (cnt_d < CNT_W'(ACTIVE));
      start_d_c_o  = (cnt_d == '0);
      wrap_c_o     = wrap;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         sync_q <= (SYNC_START == 0);
      end else begin
         cnt_q  <= cnt_d;
         sync_q <= sync_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign sync_o = sync_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel/line counters, registered strobes, frame counter and blanked Pmod output byte.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_DISPLAY        = vga_timing_pkg::H_DISPLAY,
   parameter int unsigned H_FRONT          = vga_timing_pkg::H_FRONT,
   parameter int unsigned H_SYNC           = vga_timing_pkg::H_SYNC,
   parameter int unsigned H_BACK           = vga_timing_pkg::H_BACK,
   parameter int unsigned V_DISPLAY        = vga_timing_pkg::V_DISPLAY,
   parameter int unsigned V_FRONT          = vga_timing_pkg::V_FRONT,
   parameter int unsigned V_SYNC           = vga_timing_pkg::V_SYNC,
   parameter int unsigned V_BACK           = vga_timing_pkg::V_BACK,
   parameter int unsigned SYNC_ACTIVE_HIGH = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   input  logic [1:0]         r_in,
   input  logic [1:0]         g_in,
   input  logic [1:0]         b_in,
   output logic [CNT_W-1:0]   pix_x,
   output logic [CNT_W-1:0]   pix_y,
   output logic               display_on,
   output logic               frame_start,
   output logic               line_start,
   output logic [FRAME_W-1:0] frame_cnt,
   output logic [PMOD_W-1:0]  uo_out
);

   localparam int unsigned H_TOT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned H_SS  = H_DISPLAY + H_FRONT;
   localparam int unsigned V_SS  = V_DISPLAY + V_FRONT;
   localparam logic        SYNC_INV = (SYNC_ACTIVE_HIGH == 0);

   logic h_wrap, h_active_d, h_start_d, h_sync;
   logic v_wrap, v_active_d, v_start_d, v_sync;
   logic v_en;

   logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
   logic               display_on_q, display_on_d;
   logic               frame_start_q, frame_start_d;
   logic               line_start_q, line_start_d;
   logic [PMOD_W-1:0]  uo_q, uo_d;
   logic [1:0]         r_bl, g_bl, b_bl;

   assign v_en = ena & h_wrap;

   vga_axis_counter #(
      .TOTAL     (H_TOT),
      .SYNC_START(H_SS),
      .SYNC_END  (H_SS + H_SYNC - 1),
      .ACTIVE    (H_DISPLAY)
   ) u_h (
      .clk         (clk),
      .rst_n       (rst_n),
      .en_i        (ena),
      .cnt_o       (pix_x),
      .wrap_c_o    (h_wrap),
      .active_d_c_o(h_active_d),
      .start_d_c_o (h_start_d),
      .sync_o      (h_sync)
   );

   vga_axis_counter #(
      .TOTAL     (V_TOT),
      .SYNC_START(V_SS),
      .SYNC_END  (V_SS + V_SYNC - 1),
      .ACTIVE    (V_DISPLAY)
   ) u_v (
      .clk         (clk),
      .rst_n       (rst_n),
      .en_i        (v_en),
      .cnt_o       (pix_y),
      .wrap_c_o    (v_wrap),
      .active_d_c_o(v_active_d),
      .start_d_c_o (v_start_d),
      .sync_o      (v_sync)
   );

   // Output byte is built from the pre-edge counter state, so syncs and colour share one cycle of lag.
   always_comb begin
      frame_cnt_d   = frame_cnt_q;
      if (v_en && v_wrap) begin
         frame_cnt_d = frame_cnt_q + FRAME_W'(1);
      end
      display_on_d  = h_active_d & v_active_d;
      frame_start_d = h_start_d & v_start_d;
      line_start_d  = h_start_d;
      r_bl          = display_on_q ? r_in : 2'b00;
      g_bl          = display_on_q ? g_in : 2'b00;
      b_bl          = display_on_q ? b_in : 2'b00;
      uo_d          = pmod_pack(h_sync ^ SYNC_INV, v_sync ^ SYNC_INV, r_bl, g_bl, b_bl);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt_q   <= '0;
         display_on_q  <= 1'b1;
         frame_start_q <= 1'b1;
         line_start_q  <= 1'b1;
         uo_q          <= pmod_pack(SYNC_INV, SYNC_INV, 2'b00, 2'b00, 2'b00);
      end else if (ena) begin
         frame_cnt_q   <= frame_cnt_d;
         display_on_q  <= display_on_d;
         frame_start_q <= frame_start_d;
         line_start_q  <= line_start_d;
         uo_q          <= uo_d;
      end
   end

   assign frame_cnt   = frame_cnt_q;
   assign display_on  = display_on_q;
   assign frame_start = frame_start_q;
   assign line_start  = line_start_q;
   assign uo_out      = uo_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default, active-high-sync and miniature-timing instances against an arithmetic model.
module tb_vga_sync_gen;

   typedef struct packed {
      int   hd; int hf; int hs; int hb;
      int   vd; int vf; int vs; int vb;
      logic sah;
   } cfg_t;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic [7:0] fc;
      logic       on;
      logic       fs;
      logic       ls;
      logic [7:0] uo;
   } exp_t;

   localparam cfg_t C_MAIN = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
   localparam cfg_t C_POL  = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b1};
   localparam cfg_t C_SM   = '{8, 2, 3, 2, 4, 1, 2, 1, 1'b0};

   logic       clk = 1'b0;
   logic       rst_n, ena;
   logic [1:0] r_in, g_in, b_in;

   logic [9:0] m_x, m_y, p_x, p_y, s_x, s_y;
   logic       m_on, m_fs, m_ls, p_on, p_fs, p_ls, s_on, s_fs, s_ls;
   logic [7:0] m_fc, m_uo, p_fc, p_uo, s_fc, s_uo;

   int         checks = 0;
   int         errors = 0;
   int         n = 0;
   logic [1:0] lr = 2'b00, lg = 2'b00, lb = 2'b00;
   logic       meas = 1'b0;
   int         hs_low = 0, pol_hs_high = 0, ls_cnt = 0;

   always #5 clk = ~clk;

   vga_sync_gen dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .r_in(r_in), .g_in(g_in), .b_in(b_in),
      .pix_x(m_x), .pix_y(m_y), .display_on(m_on), .frame_start(m_fs),
      .line_start(m_ls), .frame_cnt(m_fc), .uo_out(m_uo)
   );

   vga_sync_gen #(.SYNC_ACTIVE_HIGH(1)) dut_pol (
      .clk(clk), .rst_n(rst_n), .ena(ena), .r_in(r_in), .g_in(g_in), .b_in(b_in),
      .pix_x(p_x), .pix_y(p_y), .display_on(p_on), .frame_start(p_fs),
      .line_start(p_ls), .frame_cnt(p_fc), .uo_out(p_uo)
   );

   vga_sync_gen #(
      .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
   ) dut_sm (
      .clk(clk), .rst_n(rst_n), .ena(ena), .r_in(r_in), .g_in(g_in), .b_in(b_in),
      .pix_x(s_x), .pix_y(s_y), .display_on(s_on), .frame_start(s_fs),
      .line_start(s_ls), .frame_cnt(s_fc), .uo_out(s_uo)
   );

   // State after k enabled edges since reset; uo_out reflects state k-1 and the colour sampled at edge k.
   function automatic exp_t model(input cfg_t c, input int k, input logic [1:0] r,
                                  input logic [1:0] g, input logic [1:0] b);
      exp_t e;
      int ht, vt, px, py;
      logic hsr, vsr, onp, hp, vp;
      logic [1:0] rr, gg, bb;
      ht   = c.hd + c.hf + c.hs + c.hb;
      vt   = c.vd + c.vf + c.vs + c.vb;
      e.x  = 10'(k % ht);
      e.y  = 10'((k / ht) % vt);
      e.fc = 8'((k / (ht * vt)) % 256);
      e.on = ((k % ht) < c.hd) && (((k / ht) % vt) < c.vd);
      e.fs = (k % (ht * vt)) == 0;
      e.ls = (k % ht) == 0;
      hsr = 1'b0; vsr = 1'b0; rr = 2'b00; gg = 2'b00; bb = 2'b00;
      if (k > 0) begin
         px  = (k - 1) % ht;
         py  = ((k - 1) / ht) % vt;
         hsr = (px >= c.hd + c.hf) && (px < c.hd + c.hf + c.hs);
         vsr = (py >= c.vd + c.vf) && (py < c.vd + c.vf + c.vs);
         onp = (px < c.hd) && (py < c.vd);
         if (onp) begin rr = r; gg = g; bb = b; end
      end
      hp   = hsr ^ !c.sah;
      vp   = vsr ^ !c.sah;
      e.uo = {hp, bb[0], gg[0], rr[0], vp, bb[1], gg[1], rr[1]};
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_dut(input string nm, input cfg_t c, input logic [9:0] x,
                            input logic [9:0] y, input logic on, input logic fs,
                            input logic ls, input logic [7:0] fc, input logic [7:0] uo);
      exp_t e;
      e = model(c, n, lr, lg, lb);
      chk({nm, ".pix_x"},       32'(x),  32'(e.x));
      chk({nm, ".pix_y"},       32'(y),  32'(e.y));
      chk({nm, ".display_on"},  32'(on), 32'(e.on));
      chk({nm, ".frame_start"}, 32'(fs), 32'(e.fs));
      chk({nm, ".line_start"},  32'(ls), 32'(e.ls));
      chk({nm, ".frame_cnt"},   32'(fc), 32'(e.fc));
      chk({nm, ".uo_out"},      32'(uo), 32'(e.uo));
   endtask

   task automatic check_all();
      check_dut("main", C_MAIN, m_x, m_y, m_on, m_fs, m_ls, m_fc, m_uo);
      check_dut("pol",  C_POL,  p_x, p_y, p_on, p_fs, p_ls, p_fc, p_uo);
      check_dut("sm",   C_SM,   s_x, s_y, s_on, s_fs, s_ls, s_fc, s_uo);
      if (meas && n >= 1 && n <= 800) begin
         hs_low      += (m_uo[7] == 1'b0) ? 1 : 0;
         pol_hs_high += (p_uo[7] == 1'b1) ? 1 : 0;
      end
      if (meas && n <= 799) ls_cnt += m_ls ? 1 : 0;
   endtask

   // Check current state at negedge, drive inputs, advance model on the enabled edge.
   task automatic cycle(input logic rst, input logic en, input logic [1:0] r,
                        input logic [1:0] g, input logic [1:0] b);
      @(negedge clk);
      check_all();
      rst_n = rst; ena = en; r_in = r; g_in = g; b_in = b;
      if (!rst) begin
         n = 0;
         #1 check_all();
      end
      @(posedge clk);
      if (rst && en) begin
         n++; lr = r; lg = g; lb = b;
      end
      #1;
   endtask

   task automatic cyc_rand(input logic rst, input logic en);
      cycle(rst, en, 2'($urandom), 2'($urandom), 2'($urandom));
   endtask

   initial begin
      rst_n = 1'b0; ena = 1'b0; r_in = 2'b00; g_in = 2'b00; b_in = 2'b00;

      repeat (4) cyc_rand(1'b0, 1'b1);
      chk("reset_uo_main", 32'(m_uo), 32'h88);
      chk("reset_uo_pol",  32'(p_uo), 32'h00);

      // Release and measure the first full line.
      meas = 1'b1;
      cyc_rand(1'b1, 1'b1);
      chk("first_edge_x", 32'(m_x), 32'd1);
      repeat (800) cyc_rand(1'b1, 1'b1);
      meas = 1'b0;
      chk("hsync_low_len",      32'(hs_low),      32'd96);
      chk("pol_hsync_high_len", 32'(pol_hs_high), 32'd96);
      chk("line_start_count",   32'(ls_cnt),      32'd1);

      // Full-white input exercises blanking in both axes.
      repeat (1600) cycle(1'b1, 1'b1, 2'b11, 2'b11, 2'b11);

      for (int i = 0; i < 800 && (n % 800) != 300; i++) cyc_rand(1'b1, 1'b1);
      chk("reach_x300", 32'(m_x), 32'd300);
      repeat (10) cyc_rand(1'b1, 1'b0);
      chk("hold_x300", 32'(m_x), 32'd300);
      cyc_rand(1'b1, 1'b1);
      chk("resume_x301", 32'(m_x), 32'd301);

      repeat (3000) cyc_rand(1'b1, ($urandom_range(0, 3) != 0));

      for (int i = 0; i < 800 && (n % 800) != 400; i++) cyc_rand(1'b1, 1'b1);
      chk("reach_x400", 32'(m_x), 32'd400);
      cyc_rand(1'b0, 1'b1);
      chk("midframe_reset_x",  32'(m_x),  32'd0);
      chk("midframe_reset_uo", 32'(m_uo), 32'h88);
      cyc_rand(1'b0, 1'b1);
      cyc_rand(1'b1, 1'b1);
      chk("post_reset_x", 32'(m_x), 32'd1);

      // Miniature timing wraps its frame counter through 255 -> 0.
      repeat (256 * 120 + 200) cyc_rand(1'b1, 1'b1);
      @(negedge clk);
      check_all();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
